// File: rtl/cdc_hs_tx_if.sv
// cdc_hs_tx_if: source-side valid/ready port plus req/ack handshake of the cdc_hs_tx synchronizer
//   wr_valid/wr_data/wr_ready : word offer from the wrclk domain
//   req/req_data              : request and held word toward the receiving domain
//   ack                       : asynchronous acknowledge from the receiving domain
//   master drives the offer and ack; slave is the transmitter
interface cdc_hs_tx_if #(
   parameter int WIDTH = 32
);
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             req;
   logic [WIDTH-1:0] req_data;
   logic             ack;
   modport master (output wr_valid, wr_data, ack, input wr_ready, req, req_data);
   modport slave  (input wr_valid, wr_data, ack, output wr_ready, req, req_data);
endinterface

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source-domain transmitter of a four-phase req/ack single-word synchronizer
//   wrclk, wr_rst_n : source clock, asynchronous active-low reset
//   bus (slave)     : wr_valid/wr_data/wr_ready in, req/req_data out, async ack in
//   busy            : handshake in progress (state not IDLE)
//   timeout_err     : sticky, req waited TIMEOUT cycles without ack; cleared by clr_err
//   xfer_cnt        : completed four-phase transfers, wrapping
module cdc_hs_tx #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024,
   parameter int CNT_W       = 16
) (
   input  logic              wrclk,
   input  logic              wr_rst_n,
   cdc_hs_tx_if.slave        bus,
   output logic              busy,
   output logic              timeout_err,
   input  logic              clr_err,
   output logic [CNT_W-1:0]  xfer_cnt
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
   localparam logic [TW-1:0] TM1  = TW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, REQ, ACKH} state_t;
   state_t                 st;
   logic                   hold_valid;
   logic [WIDTH-1:0]       hold_data;
   logic [SYNC_STAGES-1:0] sync;
   logic [TW-1:0]          wcnt;
   logic                   ack_s;
   logic                   done;
   logic                   launch;
   assign ack_s        = sync[SYNC_STAGES-1];
   assign bus.wr_ready = !hold_valid;
   assign busy         = st != IDLE;
   assign done         = st == ACKH && !ack_s;
   // IDLE waits for a receiver that is still acking after reset; ACKH relaunches as it completes
   assign launch       = hold_valid && !ack_s && st != REQ;
   always_ff @(posedge wrclk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         st           <= IDLE;
         hold_valid   <= 1'b0;
         hold_data    <= '0;
         sync         <= '0;
         wcnt         <= '0;
         bus.req      <= 1'b0;
         bus.req_data <= '0;
         timeout_err  <= 1'b0;
         xfer_cnt     <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bus.ack};
         if (bus.wr_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= bus.wr_data;
         end else if (launch) begin
            hold_valid <= 1'b0;
         end
         if (launch) begin
            bus.req_data <= hold_data;
            bus.req      <= 1'b1;
            wcnt         <= '0;
            st           <= REQ;
         end else if (st == REQ) begin
            wcnt <= wcnt == TMAX ? wcnt : wcnt + 1'b1;
            if (ack_s) begin
               bus.req <= 1'b0;
               st      <= ACKH;
            end
         end else if (done) begin
            st <= IDLE;
         end
         if (done) xfer_cnt <= xfer_cnt + 1'b1;
         // set on the cycle the wait count reaches TIMEOUT; set beats a simultaneous clear
         timeout_err <= (st == REQ && wcnt == TM1) || (timeout_err && !clr_err);
      end
   end
endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed scoreboard bench for cdc_hs_tx with an auto-acking receiver model
module tb_cdc_hs_tx;
   logic        wrclk = 1'b0;
   logic        wr_rst_n = 1'b0;
   logic        clr_err = 1'b0;
   logic        busy;
   logic        timeout_err;
   logic [3:0]  xfer_cnt;
   logic        auto_ack = 1'b0;
   logic        man_ack = 1'b0;
   logic        resp_ack = 1'b0;
   logic        prev_req = 1'b0;
   logic [31:0] cur = '0;
   logic [31:0] q[$];
   int          rc = 0;
   int          total = 0;
   int          passed = 0;

   cdc_hs_tx_if #(.WIDTH(32)) bus ();
   assign bus.ack = auto_ack ? resp_ack : man_ack;

   cdc_hs_tx #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(16), .CNT_W(4)) dut (
      .wrclk(wrclk), .wr_rst_n(wr_rst_n), .bus(bus.slave), .busy(busy),
      .timeout_err(timeout_err), .clr_err(clr_err), .xfer_cnt(xfer_cnt));

   always #5 wrclk = ~wrclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // receiver: follows req with ack three cycles later, both edges
   always @(posedge wrclk) begin
      #1;
      if (!auto_ack) begin
         resp_ack = 1'b0;
         rc = 0;
      end else if (bus.req !== resp_ack) begin
         rc++;
         if (rc == 3) begin
            resp_ack = bus.req;
            rc = 0;
         end
      end else rc = 0;
   end

   always @(posedge wrclk)
      if (wr_rst_n && bus.wr_valid && bus.wr_ready) q.push_back(bus.wr_data);

   always @(negedge wrclk or negedge wr_rst_n) begin
      if (!wr_rst_n) prev_req = 1'b0;
      else begin
         if (bus.req && !prev_req) begin
            chk("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
               cur = q.pop_front();
               chk("req_data_launch", bus.req_data, cur);
            end
         end
         if (!bus.req && prev_req) chk("req_data_hold", bus.req_data, cur);
         prev_req = bus.req;
      end
   end

   task automatic do_reset();
      wr_rst_n = 1'b0;
      bus.wr_valid = 1'b0;
      clr_err = 1'b0;
      repeat (3) @(negedge wrclk);
      q.delete();
      wr_rst_n = 1'b1;
   endtask

   task automatic push(input logic [31:0] d);
      int n = 0;
      bus.wr_data = d;
      bus.wr_valid = 1'b1;
      while (!bus.wr_ready && n < 300) begin
         @(negedge wrclk);
         n++;
      end
      chk("accept_bound", n < 300, 1);
      @(negedge wrclk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_req(input logic v, input string tag);
      int n = 0;
      while (bus.req !== v && n < 100) begin
         @(negedge wrclk);
         n++;
      end
      chk(tag, n < 100, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge wrclk);
         #1;
         n++;
      end while (!(busy === 1'b0 && bus.wr_ready === 1'b1 && q.size() == 0) && n < 500);
      chk(tag, n < 500, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_data = '0;
      do_reset();
      chk("rst_req", bus.req, 0);
      chk("rst_req_data", bus.req_data, 0);
      chk("rst_wr_ready", bus.wr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_xfer_cnt", xfer_cnt, 0);
      // single word
      auto_ack = 1'b1;
      push(32'hA5A5_0001);
      chk("single_held_ready", bus.wr_ready, 0);
      chk("single_req_pre", bus.req, 0);
      @(negedge wrclk);
      chk("single_req_rise", bus.req, 1);
      chk("single_busy", busy, 1);
      wait_req(1'b0, "single_req_fall");
      wait_idle("single_idle");
      chk("single_xfer_cnt", xfer_cnt, 1);
      chk("single_req_data", bus.req_data, 32'hA5A5_0001);
      chk("single_ready", bus.wr_ready, 1);
      // back-to-back
      do_reset();
      push(32'h10);
      push(32'h11);
      chk("b2b_ready_full", bus.wr_ready, 0);
      push(32'h12);
      push(32'h13);
      wait_idle("b2b_idle");
      chk("b2b_xfer_cnt", xfer_cnt, 4);
      chk("b2b_last_data", bus.req_data, 32'h13);
      // timeout
      do_reset();
      auto_ack = 1'b0;
      push(32'hDEAD_0001);
      @(negedge wrclk);
      chk("to_req_rise", bus.req, 1);
      repeat (15) @(negedge wrclk);
      chk("to_err_before", timeout_err, 0);
      @(negedge wrclk);
      chk("to_err_at16", timeout_err, 1);
      chk("to_req_held", bus.req, 1);
      repeat (5) @(negedge wrclk);
      chk("to_req_still", bus.req, 1);
      man_ack = 1'b1;
      wait_req(1'b0, "to_req_fall");
      man_ack = 1'b0;
      wait_idle("to_idle");
      chk("to_xfer_cnt", xfer_cnt, 1);
      chk("to_err_sticky", timeout_err, 1);
      clr_err = 1'b1;
      @(negedge wrclk);
      clr_err = 1'b0;
      chk("to_err_cleared", timeout_err, 0);
      // set/clear collision
      do_reset();
      push(32'hC0_11DE);
      @(negedge wrclk);
      chk("col_req_rise", bus.req, 1);
      repeat (15) @(negedge wrclk);
      clr_err = 1'b1;
      @(negedge wrclk);
      clr_err = 1'b0;
      chk("col_set_wins", timeout_err, 1);
      clr_err = 1'b1;
      @(negedge wrclk);
      clr_err = 1'b0;
      chk("col_clear_after", timeout_err, 0);
      // reset mid-handshake
      do_reset();
      push(32'h0000_00A1);
      push(32'h0000_00B2);
      chk("rmid_req", bus.req, 1);
      chk("rmid_full", bus.wr_ready, 0);
      #2;
      man_ack = 1'b1;
      wr_rst_n = 1'b0;
      #1;
      chk("rmid_req_drop", bus.req, 0);
      chk("rmid_ready", bus.wr_ready, 1);
      chk("rmid_busy", busy, 0);
      q.delete();
      @(negedge wrclk);
      @(negedge wrclk);
      wr_rst_n = 1'b1;
      repeat (4) @(negedge wrclk);
      push(32'h0000_00C3);
      for (int i = 0; i < 8; i++) begin
         @(negedge wrclk);
         chk("rmid_no_req_ack_hi", bus.req, 0);
      end
      auto_ack = 1'b1;
      wait_req(1'b1, "rmid_req_after_release");
      chk("rmid_no_spurious", xfer_cnt, 0);
      wait_idle("rmid_idle");
      chk("rmid_xfer_cnt", xfer_cnt, 1);
      man_ack = 1'b0;
      // counter wrap
      do_reset();
      for (int i = 0; i < 17; i++) push(32'h100 + i);
      wait_idle("wrap_idle");
      chk("wrap_xfer_cnt", xfer_cnt, 1);
      chk("wrap_last_data", bus.req_data, 32'h110);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
